// File: rtl/rpn_executor.sv
// rtl/rpn_executor.sv - RPN command sequencer driving the operand stack strobes
// Simple ops resolve in one EXEC cycle; DIV runs a restoring divider then writes back.
module rpn_executor #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [3:0]       cmd_digit,
    input  logic [WIDTH-1:0] stack_top,
    input  logic [WIDTH-1:0] stack_next,
    input  logic [5:0]       stack_count,
    input  logic             stack_error,
    output logic             stack_push,
    output logic             stack_pop,
    output logic             stack_write,
    output logic [WIDTH-1:0] stack_value,
    output logic             done,
    output logic             err_underflow,
    output logic             err_div0,
    output logic             err_overflow
);
    localparam logic [3:0] OP_DIGIT = 4'd0, OP_ENTER = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3,
                           OP_MUL = 4'd4, OP_DIV = 4'd5, OP_NEG = 4'd6, OP_DROP = 4'd7,
                           OP_BKSP = 4'd8, OP_CLRF = 4'd15;
    localparam int CW = $clog2(WIDTH);
    localparam logic signed [WIDTH-1:0] TEN = WIDTH'(10);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DIV, S_WB} state_t;
    state_t state, nxt_state;

    logic             n_push, n_pop, n_write, n_done, n_unf, n_dz, n_ovf;
    logic [WIDTH-1:0] n_value;
    logic             div_start, div_step, wb_fire;
    logic [WIDTH-1:0] div_q, div_rem, div_dvs;
    logic             div_neg;
    logic [CW-1:0]    div_cnt;
    logic [3:0]       digit_val;
    logic             binary_ok;
    logic [WIDTH:0]   div_shift, div_diff;

    assign cmd_ready = (state == S_IDLE);
    assign digit_val = (cmd_digit > 4'd9) ? 4'd0 : cmd_digit;
    assign binary_ok = (stack_count > 6'd1);
    assign div_shift = {div_rem, div_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, div_dvs};

    always_comb begin
        nxt_state = state;
        n_push    = 1'b0;
        n_pop     = 1'b0;
        n_write   = 1'b0;
        n_value   = '0;
        n_done    = 1'b0;
        n_unf     = err_underflow;
        n_dz      = err_div0;
        n_ovf     = err_overflow | stack_error;
        div_start = 1'b0;
        div_step  = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    nxt_state = S_EXEC;
                    n_done    = 1'b1;
                    case (cmd_op)
                        OP_DIGIT: begin
                            n_write = 1'b1;
                            n_value = stack_top * WIDTH'(10) + WIDTH'(digit_val);
                        end
                        OP_ENTER: begin
                            if (stack_count >= 6'(DEPTH)) n_ovf = 1'b1;
                            else n_push = 1'b1;
                        end
                        OP_ADD, OP_SUB, OP_MUL: begin
                            if (!binary_ok) n_unf = 1'b1;
                            else begin
                                n_pop   = 1'b1;
                                n_write = 1'b1;
                                if (cmd_op == OP_ADD)      n_value = stack_next + stack_top;
                                else if (cmd_op == OP_SUB) n_value = stack_next - stack_top;
                                else                       n_value = stack_next * stack_top;
                            end
                        end
                        OP_DIV: begin
                            if (!binary_ok) n_unf = 1'b1;
                            else if (stack_top == '0) n_dz = 1'b1;
                            else begin
                                nxt_state = S_DIV;
                                n_done    = 1'b0;
                                div_start = 1'b1;
                            end
                        end
                        OP_NEG: begin
                            n_write = 1'b1;
                            n_value = -stack_top;
                        end
                        OP_DROP: begin
                            if (binary_ok) n_pop = 1'b1;
                            else n_write = 1'b1;
                        end
                        OP_BKSP: begin
                            n_write = 1'b1;
                            n_value = $signed(stack_top) / TEN;
                        end
                        OP_CLRF: begin
                            n_unf = 1'b0;
                            n_dz  = 1'b0;
                            n_ovf = stack_error;
                        end
                        default: ;
                    endcase
                end
            end
            S_EXEC: nxt_state = S_IDLE;
            S_DIV: begin
                div_step = 1'b1;
                if (div_cnt == CW'(WIDTH - 1)) nxt_state = S_WB;
            end
            S_WB: begin
                // First WB cycle registers the signed quotient; the second presents it
                if (!wb_fire) begin
                    n_pop   = 1'b1;
                    n_write = 1'b1;
                    n_done  = 1'b1;
                    n_value = div_neg ? -div_q : div_q;
                end else begin
                    nxt_state = S_IDLE;
                end
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= nxt_state;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stack_push    <= 1'b0;
            stack_pop     <= 1'b0;
            stack_write   <= 1'b0;
            stack_value   <= '0;
            done          <= 1'b0;
            err_underflow <= 1'b0;
            err_div0      <= 1'b0;
            err_overflow  <= 1'b0;
            wb_fire       <= 1'b0;
        end else begin
            stack_push    <= n_push;
            stack_pop     <= n_pop;
            stack_write   <= n_write;
            stack_value   <= n_value;
            done          <= n_done;
            err_underflow <= n_unf;
            err_div0      <= n_dz;
            err_overflow  <= n_ovf;
            wb_fire       <= (state == S_WB) && !wb_fire;
        end
    end

    // Restoring divide on magnitudes; div_q shifts the dividend out and quotient bits in
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_q   <= '0;
            div_rem <= '0;
            div_dvs <= '0;
            div_neg <= 1'b0;
            div_cnt <= '0;
        end else if (div_start) begin
            div_q   <= stack_next[WIDTH-1] ? -stack_next : stack_next;
            div_dvs <= stack_top[WIDTH-1] ? -stack_top : stack_top;
            div_rem <= '0;
            div_neg <= stack_next[WIDTH-1] ^ stack_top[WIDTH-1];
            div_cnt <= '0;
        end else if (div_step) begin
            if (!div_diff[WIDTH]) begin
                div_rem <= div_diff[WIDTH-1:0];
                div_q   <= {div_q[WIDTH-2:0], 1'b1};
            end else begin
                div_rem <= div_shift[WIDTH-1:0];
                div_q   <= {div_q[WIDTH-2:0], 1'b0};
            end
            div_cnt <= div_cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_rpn_executor.sv
// tb/tb_rpn_executor.sv - directed vector bench for rpn_executor with a behavioural stack
module tb_rpn_executor;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = 4'd0;
    logic [3:0]  cmd_digit = 4'd0;
    logic [31:0] stack_top, stack_next, stack_value;
    logic [5:0]  stack_count;
    logic        stack_error = 1'b0;
    logic        stack_push, stack_pop, stack_write, done;
    logic        err_underflow, err_div0, err_overflow;

    int n_chk = 0;
    int n_fail = 0;

    always #10 clock = ~clock;

    rpn_executor #(.WIDTH(32), .DEPTH(32)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_digit(cmd_digit), .stack_top(stack_top), .stack_next(stack_next),
        .stack_count(stack_count), .stack_error(stack_error), .stack_push(stack_push),
        .stack_pop(stack_pop), .stack_write(stack_write), .stack_value(stack_value),
        .done(done), .err_underflow(err_underflow), .err_div0(err_div0), .err_overflow(err_overflow)
    );

    // Behavioural 32-entry stack reacting to the registered strobes
    logic [31:0] st [0:31];
    int cnt;
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt   <= 1;
            st[0] <= 32'd0;
        end else if (stack_push) begin
            if (cnt < 32) begin
                st[cnt] <= 32'd0;
                cnt     <= cnt + 1;
            end
        end else if (stack_pop && cnt > 1) begin
            cnt <= cnt - 1;
            if (stack_write) st[cnt-2] <= stack_value;
        end else if (stack_write) begin
            st[cnt-1] <= stack_value;
        end
    end
    assign stack_top   = st[cnt-1];
    assign stack_next  = (cnt > 1) ? st[cnt-2] : 32'd0;
    assign stack_count = 6'(cnt);

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  dg;
        logic [3:0]  strb;   // {done, push, pop, write}
        logic [31:0] value;
        int          lat;
        logic [31:0] top;
        int          count;
        logic [2:0]  flags;  // {underflow, div0, overflow}
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [3:0] dg,
                           output logic [3:0] strb, output logic [31:0] val, output int lat);
        int guard;
        guard = 0;
        @(negedge clock);
        while (!cmd_ready && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_digit = dg;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 4'd0;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
        strb = {done, stack_push, stack_pop, stack_write};
        val  = stack_value;
        @(posedge clock);
        #1;
    endtask

    task automatic quick(input logic [3:0] op, input logic [3:0] dg);
        logic [3:0] s;
        logic [31:0] v;
        int l;
        run_cmd(op, dg, s, v, l);
    endtask

    initial begin
        logic [3:0]  s;
        logic [31:0] v;
        int          l, low, done_at, seen;
        logic [3:0]  minint_digits [10];

        //              op   dg   strb     value         lat top           cnt flags
        vecs.push_back('{4'd0, 4'd1, 4'b1001, 32'd1,        0, 32'd1,        1, 3'b000});
        vecs.push_back('{4'd0, 4'd2, 4'b1001, 32'd12,       0, 32'd12,       1, 3'b000});
        vecs.push_back('{4'd0, 4'd3, 4'b1001, 32'd123,      0, 32'd123,      1, 3'b000});
        vecs.push_back('{4'd8, 4'd0, 4'b1001, 32'd12,       0, 32'd12,       1, 3'b000});
        vecs.push_back('{4'd7, 4'd0, 4'b1001, 32'd0,        0, 32'd0,        1, 3'b000});
        vecs.push_back('{4'd0, 4'd7, 4'b1001, 32'd7,        0, 32'd7,        1, 3'b000});
        vecs.push_back('{4'd1, 4'd0, 4'b1100, 32'd0,        0, 32'd0,        2, 3'b000});
        vecs.push_back('{4'd0, 4'd5, 4'b1001, 32'd5,        0, 32'd5,        2, 3'b000});
        vecs.push_back('{4'd3, 4'd0, 4'b1011, 32'd2,        0, 32'd2,        1, 3'b000});
        vecs.push_back('{4'd6, 4'd0, 4'b1001, 32'hFFFFFFFE, 0, 32'hFFFFFFFE, 1, 3'b000});
        vecs.push_back('{4'd0, 4'd9, 4'b1001, 32'hFFFFFFF5, 0, 32'hFFFFFFF5, 1, 3'b000});
        vecs.push_back('{4'd1, 4'd0, 4'b1100, 32'd0,        0, 32'd0,        2, 3'b000});
        vecs.push_back('{4'd0, 4'd2, 4'b1001, 32'd2,        0, 32'd2,        2, 3'b000});
        vecs.push_back('{4'd5, 4'd0, 4'b1011, 32'hFFFFFFFB, 33, 32'hFFFFFFFB, 1, 3'b000});
        vecs.push_back('{4'd1, 4'd0, 4'b1100, 32'd0,        0, 32'd0,        2, 3'b000});
        vecs.push_back('{4'd0, 4'd3, 4'b1001, 32'd3,        0, 32'd3,        2, 3'b000});
        vecs.push_back('{4'd4, 4'd0, 4'b1011, 32'hFFFFFFF1, 0, 32'hFFFFFFF1, 1, 3'b000});
        vecs.push_back('{4'd1, 4'd0, 4'b1100, 32'd0,        0, 32'd0,        2, 3'b000});
        vecs.push_back('{4'd0, 4'd4, 4'b1001, 32'd4,        0, 32'd4,        2, 3'b000});
        vecs.push_back('{4'd2, 4'd0, 4'b1011, 32'hFFFFFFF5, 0, 32'hFFFFFFF5, 1, 3'b000});
        vecs.push_back('{4'd2, 4'd0, 4'b1000, 32'd0,        0, 32'hFFFFFFF5, 1, 3'b100});
        vecs.push_back('{4'd1, 4'd0, 4'b1100, 32'd0,        0, 32'd0,        2, 3'b100});
        vecs.push_back('{4'd5, 4'd0, 4'b1000, 32'd0,        0, 32'd0,        2, 3'b110});
        vecs.push_back('{4'd15, 4'd0, 4'b1000, 32'd0,       0, 32'd0,        2, 3'b000});
        vecs.push_back('{4'd7, 4'd0, 4'b1010, 32'd0,        0, 32'hFFFFFFF5, 1, 3'b000});
        vecs.push_back('{4'd0, 4'd12, 4'b1001, 32'hFFFFFF92, 0, 32'hFFFFFF92, 1, 3'b000});
        vecs.push_back('{4'd10, 4'd0, 4'b1000, 32'd0,       0, 32'hFFFFFF92, 1, 3'b000});
        vecs.push_back('{4'd8, 4'd0, 4'b1001, 32'hFFFFFFF5, 0, 32'hFFFFFFF5, 1, 3'b000});
        vecs.push_back('{4'd8, 4'd0, 4'b1001, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 1, 3'b000});

        // Reset state, sampled while reset is held low
        #15;
        chk("reset_strobes", {28'd0, done, stack_push, stack_pop, stack_write}, 32'd0);
        chk("reset_value", stack_value, 32'd0);
        chk("reset_flags", {29'd0, err_underflow, err_div0, err_overflow}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("reset_ready", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            run_cmd(vecs[i].op, vecs[i].dg, s, v, l);
            chk($sformatf("v%0d_strobes", i), {28'd0, s}, {28'd0, vecs[i].strb});
            if (vecs[i].strb[0]) chk($sformatf("v%0d_value", i), v, vecs[i].value);
            chk($sformatf("v%0d_latency", i), l, vecs[i].lat);
            chk($sformatf("v%0d_top", i), stack_top, vecs[i].top);
            chk($sformatf("v%0d_count", i), cnt, vecs[i].count);
            chk($sformatf("v%0d_flags", i), {29'd0, err_underflow, err_div0, err_overflow},
                {29'd0, vecs[i].flags});
        end

        // -7 / 2: ready low for 34 cycles, WB strobes 33 edges after acceptance
        do_reset();
        quick(4'd0, 4'd7);
        quick(4'd6, 4'd0);
        quick(4'd1, 4'd0);
        quick(4'd0, 4'd2);
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_op    = 4'd5;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        low = 0;
        done_at = -1;
        v = 32'd0;
        s = 4'd0;
        for (int i = 0; i < 60; i++) begin
            if (!cmd_ready) low++;
            if (done && done_at < 0) begin
                done_at = i;
                v = stack_value;
                s = {done, stack_push, stack_pop, stack_write};
            end
            @(posedge clock);
            #1;
        end
        chk("div_ready_low_cycles", low, 34);
        chk("div_done_edge", done_at, 33);
        chk("div_wb_value", v, 32'hFFFFFFFD);
        chk("div_wb_strobes", {28'd0, s}, 32'b1011);
        chk("div_result_top", stack_top, 32'hFFFFFFFD);

        // -2^31 / -1 wraps back to -2^31
        do_reset();
        minint_digits = '{4'd2, 4'd1, 4'd4, 4'd7, 4'd4, 4'd8, 4'd3, 4'd6, 4'd4, 4'd8};
        for (int i = 0; i < 10; i++) quick(4'd0, minint_digits[i]);
        quick(4'd6, 4'd0);
        quick(4'd1, 4'd0);
        quick(4'd0, 4'd1);
        quick(4'd6, 4'd0);
        run_cmd(4'd5, 4'd0, s, v, l);
        chk("minint_div_value", v, 32'h80000000);
        chk("minint_div_latency", l, 33);

        // Fill to DEPTH, then one ENTER too many, then DROP at full
        do_reset();
        for (int i = 0; i < 31; i++) quick(4'd1, 4'd0);
        chk("full_count", cnt, 32);
        run_cmd(4'd1, 4'd0, s, v, l);
        chk("enter_full_strobes", {28'd0, s}, 32'b1000);
        chk("enter_full_ovf", {31'd0, err_overflow}, 32'd1);
        chk("enter_full_count", cnt, 32);
        run_cmd(4'd7, 4'd0, s, v, l);
        chk("drop_full_strobes", {28'd0, s}, 32'b1010);
        chk("drop_full_count", cnt, 31);

        // External stack_error pulse sets the sticky overflow flag
        quick(4'd15, 4'd0);
        chk("clr_ovf", {31'd0, err_overflow}, 32'd0);
        @(negedge clock);
        stack_error = 1'b1;
        @(negedge clock);
        stack_error = 1'b0;
        @(negedge clock);
        chk("stack_error_ovf", {31'd0, err_overflow}, 32'd1);

        // Reset in the middle of a divide aborts it without any stack write
        do_reset();
        quick(4'd0, 4'd9);
        quick(4'd1, 4'd0);
        quick(4'd0, 4'd2);
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_op    = 4'd5;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        chk("mid_div_busy", {31'd0, cmd_ready}, 32'd0);
        reset = 1'b0;
        #1;
        chk("mid_div_rst_strobes", {28'd0, done, stack_push, stack_pop, stack_write}, 32'd0);
        chk("mid_div_rst_idle", {31'd0, cmd_ready}, 32'd1);
        @(negedge clock);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (stack_push || stack_pop || stack_write || done) seen++;
        end
        chk("post_abort_no_strobes", seen, 0);
        chk("post_abort_ready", {31'd0, cmd_ready}, 32'd1);
        chk("post_abort_flags", {29'd0, err_underflow, err_div0, err_overflow}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rpn_executor.md
# rpn_executor

Command sequencer for the calculator datapath; it sits on the driving side of the 32-entry operand stack. It accepts one keypad/command operation at a time over a valid/ready handshake, reads the stack's `top`/`next`/`count`, computes the result, and issues the matching push/pop/write strobes with the value to write. Arithmetic is 32-bit two's complement. Division is multi-cycle; every other operation is single-issue.

## Interface
- `WIDTH`, 32, operand and stack word width
- `DEPTH`, 32, stack capacity in words; `count` must never exceed it
- `clock` in 1: 50 MHz system clock
- `reset` in 1: asynchronous, active-low reset
- `cmd_valid` in 1: command present
- `cmd_ready` out 1: executor can accept; a transfer occurs when `cmd_valid & cmd_ready` at a rising edge
- `cmd_op` in 4: 0 DIGIT, 1 ENTER, 2 ADD, 3 SUB, 4 MUL, 5 DIV, 6 NEG, 7 DROP, 8 BACKSPACE, 15 CLRFLAGS; other codes are no-ops
- `cmd_digit` in 4: decimal digit 0–9 for DIGIT; values 10–15 are treated as 0
- `stack_top` in WIDTH: current top element
- `stack_next` in WIDTH: second element (0 when `count`==1)
- `stack_count` in 6: elements held (1..DEPTH)
- `stack_error` in 1: stack overflow indication
- `stack_push` out 1, `stack_pop` out 1, `stack_write` out 1: stack strobes (registered)
- `stack_value` out WIDTH: value written when `stack_write`=1
- `done` out 1: one-cycle pulse at command completion
- `err_underflow`, `err_div0`, `err_overflow` out 1 each: sticky status flags

## Operation
- Stack contract: push places a new 0 on top; write overwrites top; pop+write in one cycle removes top and overwrites the new top with `stack_value`; the stack always holds ≥1 element.
- FSM states: IDLE, EXEC, DIV, WB.
  - IDLE: `cmd_ready`=1. On transfer, latch op, digit, `stack_top` as A, `stack_next` as B, and `stack_count`. Go to DIV for DIV with a legal operand, else EXEC.
  - EXEC: one cycle with strobes/`stack_value` per op and `done`=1. Next state IDLE.
  - DIV: 32-iteration restoring divide of |B|/|A|, one quotient bit per cycle. Go to WB.
  - WB: pop+write of quotient, `done`=1. Next state IDLE.
- Per-op effect (X = result, stored in low WIDTH bits, wrapping silently):
  - DIGIT: write A*10+d.
  - ENTER: push only.
  - ADD/SUB/MUL: pop+write B+A, B−A, or low 32 bits of B*A.
  - DIV: pop+write B/A, truncated toward zero; sign = sign(B) xor sign(A). −2^31/−1 wraps to −2^31.
  - NEG: write −A.
  - BACKSPACE: write A/10, truncated toward zero.
  - DROP: pop when count>1; when count==1, write 0.
  - CLRFLAGS: clears all three flags; no strobes.
- Refusals: the command completes through EXEC with `done`=1 but no strobes.
  - Binary op with count==1 sets `err_underflow`.
  - DIV with A==0 sets `err_div0` and skips DIV.
  - ENTER with count==DEPTH sets `err_overflow`.
  - `stack_error`=1 sampled in any cycle also sets `err_overflow`.
- At most one of `stack_push`/`stack_pop` is high in any cycle. Push is never combined with write.

## Timing
- Reset (low) forces IDLE immediately, asynchronously. Reset values: all strobes 0, `stack_value`=0, `done`=0, flags 0, `cmd_ready`=1 once reset deasserts.
- Reset mid-DIV aborts the divide with no stack write.
- Simple op: accepted at edge N; strobes and `done` high from edge N to N+1; stack updates at edge N+1; `cmd_ready` high again after edge N+1.
- Throughput for simple ops: 1 command per 2 cycles. The stack result is visible on `stack_top` the cycle after the strobe cycle, i.e. before the next command can be latched.
- DIV: accepted at edge N; DIV state occupies 32 cycles; WB strobes from edge N+33 to N+34; latency 34 cycles.
- `cmd_ready`=0 in EXEC, DIV and WB. Inputs `cmd_op`/`cmd_digit` are ignored while not ready.
- Operands are latched at acceptance. Stack inputs changing later have no effect except `stack_error`.

## Test plan
- Reset then DIGIT 1, DIGIT 2, DIGIT 3 -> three write strobes with values 1, 12, 123; `stack_push`/`stack_pop` never high; `done` pulses 3 times.
- Sequence 7 ENTER 5 SUB -> ENTER push; SUB cycle has pop=1, write=1, `stack_value`=2; count returns to 1.
- Sequence −7 (7, NEG), ENTER 2 DIV -> `cmd_ready` low for 34 cycles; WB writes −3 (0xFFFFFFFD) with pop.
- ENTER 0 DIV -> `err_div0`=1 and no strobes; ADD with count 1 -> `err_underflow`=1; CLRFLAGS -> both flags 0.
- 31 ENTERs then one more ENTER -> final ENTER gives no push and `err_overflow`=1; DROP at count 32 -> pop.
- Assert reset low at cycle 10 of DIV -> strobes stay 0, FSM in IDLE; after release `cmd_ready`=1 and flags 0.
